// File: rtl/bcd_pkg.sv
// bcd_pkg
//   Definitions shared by the BCD digit packer, the BCD-to-binary converter
//   and any later binary-to-BCD stage.
//   - BCD_DIGIT_W : width of one BCD digit
//   - BCD_MAX     : largest legal BCD digit value
//   - state_t     : packer FSM states (COLLECT, HOLD)
//   - is_bcd_digit: helper that tests one nibble for BCD legality
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_check.sv
// bcd_digit_check
//   Purely combinational legality check for one BCD nibble. Also used as the
//   input guard of the BCD-to-binary converter.
//   Ports:
//     digit  in  4  nibble to test
//     is_bcd out 1  high when digit is 0..9
module bcd_digit_check
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic                   is_bcd
);

  assign is_bcd = is_bcd_digit(digit);

endmodule

// File: rtl/bcd_digit_packer.sv
// bcd_digit_packer
//   Collects BCD digits MSD first, rejects non-BCD nibbles and digits beyond
//   the buffer capacity, and on 'enter' presents the right-aligned packed BCD
//   word downstream.
//
//   Handshakes (both strict valid/ready): a transfer happens on a rising edge
//   where valid and ready are both high. A source that raises valid keeps it
//   and its data stable until the transfer; ready never depends on valid.
//   Here digit_ready depends on state only, and bcd_valid/bcd_out are held
//   until bcd_ready. 'clear' is the only way bcd_valid drops before transfer.
//
//   Ports:
//     clk          in   clock, rising edge
//     rst_n        in   synchronous active-low reset
//     digit_valid  in   digit_in carries a digit
//     digit_in     in   BCD digit, MSD first
//     digit_ready  out  packer accepts digits (COLLECT)
//     enter        in   finish entry, present the word
//     clear        in   discard buffer and any pending word
//     bcd_out      out  packed BCD word, newest digit in [3:0]
//     bcd_valid    out  bcd_out valid
//     bcd_ready    in   downstream accepts bcd_out
//     digit_count  out  digits currently held
//     err_invalid  out  1-cycle pulse: digit > 9 rejected
//     err_overflow out  1-cycle pulse: legal digit rejected, buffer full
module bcd_digit_packer
  import bcd_pkg::*;
#(
  parameter  int NDIGITS = 4,
  localparam int W       = BCD_DIGIT_W * NDIGITS,
  localparam int CNT_W   = $clog2(NDIGITS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   digit_valid,
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic                   digit_ready,
  input  logic                   enter,
  input  logic                   clear,
  output logic [W-1:0]           bcd_out,
  output logic                   bcd_valid,
  input  logic                   bcd_ready,
  output logic [CNT_W-1:0]       digit_count,
  output logic                   err_invalid,
  output logic                   err_overflow
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(NDIGITS);

  state_t           state_q, state_d;
  logic [W-1:0]     buffer_q, buffer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             err_inv_q, err_inv_d;
  logic             err_ovf_q, err_ovf_d;
  logic             is_bcd;

  bcd_digit_check u_check (
    .digit  (digit_in),
    .is_bcd (is_bcd)
  );

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    buffer_d  = buffer_q;
    count_d   = count_q;
    valid_d   = valid_q;
    err_inv_d = 1'b0;
    err_ovf_d = 1'b0;

    if (clear) begin
      // clear wins over digit, enter and the output handshake
      state_d  = COLLECT;
      buffer_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (digit_valid) begin
            if (!is_bcd) begin
              err_inv_d = 1'b1;
            end else if (count_q == FULL) begin
              err_ovf_d = 1'b1;
            end else begin
              buffer_d = (buffer_q << BCD_DIGIT_W) | W'(digit_in);
              count_d  = count_q + CNT_W'(1);
            end
          end
          // A digit accepted in this same cycle lands in buffer_d and so
          // becomes part of the presented word.
          if (enter) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
        HOLD: begin
          // bcd_valid is always high in HOLD, so bcd_ready alone completes
          // the transfer. Digits and enter are ignored silently.
          if (bcd_ready) begin
            state_d  = COLLECT;
            buffer_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
          end
        end
        default: begin
          state_d  = COLLECT;
          buffer_d = '0;
          count_d  = '0;
          valid_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      buffer_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      err_inv_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buffer_q  <= buffer_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      err_inv_q <= err_inv_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  // All outputs come straight from registers or the state register.
  assign digit_ready  = (state_q == COLLECT);
  assign bcd_out      = buffer_q;
  assign bcd_valid    = valid_q;
  assign digit_count  = count_q;
  assign err_invalid  = err_inv_q;
  assign err_overflow = err_ovf_q;

endmodule
